// File: rtl/data_mem_responder_if.sv
// MEM-stage data port bundle: request signals from the pipeline,
// read data plus ready/err handshake back from the responder.
interface data_mem_responder_if;
    logic        MEM_W_EN;
    logic        MEM_R_EN;
    logic [31:0] address;
    logic [31:0] val_Rm;
    logic [31:0] data;
    logic        ready;
    logic        err;

    modport master (
        output MEM_W_EN, MEM_R_EN, address, val_Rm,
        input  data, ready, err
    );

    modport slave (
        input  MEM_W_EN, MEM_R_EN, address, val_Rm,
        output data, ready, err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder: latches a request in IDLE, waits
// WAIT_CYCLES in BUSY, performs the access, then signals ready for one DONE cycle.
module data_mem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);
    localparam int          IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [31:0]        r_wdata;
    logic               r_is_write;
    logic               r_in_range;
    logic [31:0]        r_data;
    logic               r_err;
    logic [31:0]        r_mem [DEPTH];

    logic               w_req;
    logic               w_in_range;
    logic               w_fire;
    logic               w_ready;
    logic [IDX_W-1:0]   w_idx;

    assign w_req      = bus.MEM_W_EN | bus.MEM_R_EN;
    assign w_in_range = bus.address < LIMIT;
    assign w_idx      = bus.address[IDX_W+1:2];
    assign w_fire     = (r_state == S_BUSY) && (r_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // Combinational so the pipeline freezes in the request cycle itself
                w_ready = ~w_req;
                if (w_req) w_state_next = S_BUSY;
            end
            S_BUSY: begin
                if (w_fire) w_state_next = S_DONE;
            end
            S_DONE: begin
                w_ready      = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign bus.ready = ~rst | w_ready;
    assign bus.data  = r_data;
    assign bus.err   = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
            r_in_range <= 1'b0;
            r_data     <= '0;
            r_err      <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_idx      <= w_idx;
                        r_wdata    <= bus.val_Rm;
                        r_is_write <= bus.MEM_W_EN;
                        r_in_range <= w_in_range;
                        r_cnt      <= CNT_W'(WAIT_CYCLES - 1);
                    end
                end
                S_BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_err <= ~r_in_range;
                        // data only moves on a completed read; writes leave it alone
                        if (!r_is_write) r_data <= r_in_range ? r_mem[r_idx] : '0;
                    end
                end
                S_DONE: r_err <= 1'b0;
                default: ;
            endcase
        end
    end

    // Array has no reset; the write is gated by the BUSY state, which reset clears
    always_ff @(posedge clk) begin
        if (w_fire && r_is_write && r_in_range) r_mem[r_idx] <= r_wdata;
    end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the MEM-stage data port. It accepts word read and write requests from the MEM stage and services them from an internal word array after a fixed number of wait cycles. A `ready` handshake lets the pipeline freeze while an access is in flight. It sits in the position of the single-cycle data memory and presents the same request signals to the MEM stage, plus `ready` and `err`.

## Interface
- `DEPTH`, 64: number of 32-bit words in the array; must be a power of two.
- `WAIT_CYCLES`, 4: number of BUSY cycles per access; must be ≥ 1.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `MEM_W_EN` input 1: write request; sampled in IDLE only.
- `MEM_R_EN` input 1: read request; sampled in IDLE only.
- `address` input 32: byte address, already offset to 0 by the MEM stage.
- `val_Rm` input 32: write data.
- `data` output 32: read data register.
- `ready` output 1: high means the access has completed or no access is pending; low means freeze the pipeline.
- `err` output 1: out-of-range flag, valid in the DONE cycle.

## Operation
- Word index is `address[log2(DEPTH)+1:2]`. `address[1:0]` is ignored (no misalignment fault).
- In range means `address < 4*DEPTH` (unsigned, 32-bit compare).
- Request priority: if both enables are high, only the write is performed and the read is dropped.
- The array is not reset. Its contents are undefined until written.
- FSM states:
  - **IDLE**
    - `ready = ~(MEM_W_EN | MEM_R_EN)`, combinational, so the pipeline freezes in the request cycle.
    - On a request: latch the address, write data, operation and range flag; load `cnt <= WAIT_CYCLES-1`; go to BUSY.
  - **BUSY**
    - `ready = 0`. Inputs are ignored; the latched copies are used.
    - When `cnt != 0`: `cnt <= cnt-1`.
    - When `cnt == 0`, perform the access at this edge, then go to DONE:
      - Write: `mem[idx] <= wdata` if in range; otherwise no write.
      - Read: `data <= mem[idx]` if in range; otherwise `data <= 0`.
      - `err <= ~in_range`.
  - **DONE**
    - `ready = 1` for exactly one cycle. Inputs are ignored.
    - Next edge: go to IDLE and clear `err`.
- `data` holds its last read value through writes, idle cycles and out-of-range writes. It changes only when a read completes.
- Reset (`rst` low) at any time, including mid-BUSY:
  - Next state is IDLE; `cnt = 0`; `data = 0`; `err = 0`; latched request fields cleared.
  - An in-flight write is abandoned and the array is unchanged.
  - While `rst` is low, `ready` is forced to 1.

## Timing
- Reset values: `data = 0`, `err = 0`, `ready = 1`.
- Request presented in cycle 0:
  - `ready` is low in cycles 0 to `WAIT_CYCLES` (`WAIT_CYCLES+1` cycles total).
  - `ready` is high in cycle `WAIT_CYCLES+1` (DONE).
  - `data` and `err` are valid from the start of the DONE cycle.
- The requester holds its enables, address and data until it sees `ready` high. The DONE-cycle edge advances the pipeline.
- A request appearing in the cycle after DONE is treated as a new access. Back-to-back accesses cost `WAIT_CYCLES+2` cycles each.
- With both enables low, the block stays in IDLE with `ready = 1` and no activity.
- A read and a write to the same word are always serialised; there is no bypass. A read after a write returns the written value.
- `cnt` width is `$clog2(WAIT_CYCLES)`, with a minimum of 1 bit. It never wraps below 0.

## Test plan
- **Reset:** drive `rst = 0` mid-simulation → `ready = 1`, `data = 0x00000000`, `err = 0` immediately (asynchronous); state is IDLE after release.
- **Write then read (`WAIT_CYCLES = 4`):**
  - Write `0xDEADBEEF` to address 8 → `ready` low cycles 0–4, high in cycle 5.
  - Read address 8 → `data = 0xDEADBEEF`, `err = 0` in its DONE cycle.
- **Back-to-back and data hold:**
  - Write 0 ← `0x1`, then write 4 ← `0x2`, then read 0 → `data = 0x1`.
  - Then write 8 ← `0x3` → `data` still `0x1`.
  - Then read 4 → `data = 0x2`.
- **Out of range (`DEPTH = 64`):**
  - Write 256 ← `0xFFFFFFFF` → `err = 1` for one cycle.
  - Read 0 → still `0x1`, so no aliasing.
  - Read 256 → `data = 0`, `err = 1`.
- **Dual enable:** with word 12 = `0x0`, drive `MEM_W_EN = MEM_R_EN = 1`, address 12, `val_Rm = 0xA5A5A5A5`.
  - `data` is unchanged in DONE.
  - A following read of 12 returns `0xA5A5A5A5`.
- **Reset mid-access:**
  - With word 12 = `0x55`, start a write of `0x99` to 12 and assert `rst` in the second BUSY cycle.
  - After release, `ready = 1` in IDLE, and a read of 12 returns `0x55`.
